// File: rtl/whack_pkg.sv
// Shared keypad geometry, key index type and index helper for the whack-a-mole front end.
package whack_pkg;

  localparam int unsigned NUM_KEYS = 16;
  localparam int unsigned KP_ROWS  = 4;
  localparam int unsigned KP_COLS  = 4;
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned COL_W    = 2;

  typedef logic [KEY_W-1:0] key_idx_t;

  // Linear key number for a (row, col) position on the keypad.
  function automatic key_idx_t key_index(input int unsigned row, input int unsigned col);
    return KEY_W'(row * KP_COLS + col);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: the stable state flips only after DB_COUNT consecutive
// disagreeing samples; rise is a same-cycle strobe for the 0->1 flip.
module key_debounce #(
  parameter int unsigned DB_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT + 1) : 1;

  logic [CNT_W-1:0] cnt;
  logic             flip_c;

  // This sample is the last disagreeing one needed to flip the stable state.
  assign flip_c = sample && (raw != stable) && (cnt == CNT_W'(DB_COUNT - 1));
  assign rise   = flip_c && raw;

  // Counter clears on agreement or on flip, otherwise counts disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sample) begin
      if (raw == stable) begin
        cnt <= '0;
      end else if (flip_c) begin
        stable <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_hit_scan.sv
// Keypad front end: column scan, per-key debounce, press capture into a
// pending mask and lowest-index-first issue of single-cycle hit pulses.
module keypad_hit_scan
  import whack_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 100000,
  parameter int unsigned DB_COUNT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [KP_ROWS-1:0]  kp_row,
  output logic [KP_COLS-1:0]  kp_col,
  output logic                hit,
  output key_idx_t            hit_index,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam int unsigned TIMER_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [TIMER_W-1:0]  timer;
  logic [COL_W-1:0]    col_sel;
  logic [COL_W-1:0]    col_nxt_c;
  logic                at_end_c;
  logic [NUM_KEYS-1:0] rise_c;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] clr_c;
  logic                pend_any_c;
  key_idx_t            low_c;

  assign at_end_c  = (timer == TIMER_W'(SCAN_CYCLES - 1));
  assign col_nxt_c = col_sel + COL_W'(1);

  // Dwell timer and column select; kp_col tracks col_sel with no lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      col_sel <= '0;
      kp_col  <= 4'b1110;
    end else if (at_end_c) begin
      timer   <= '0;
      col_sel <= col_nxt_c;
      kp_col  <= ~(4'b0001 << col_nxt_c);
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // One debouncer per key, sampled at the end of its column's dwell.
  for (genvar r = 0; r < KP_ROWS; r++) begin : g_row
    for (genvar c = 0; c < KP_COLS; c++) begin : g_col
      localparam int unsigned K = 32'(key_index(r, c));
      key_debounce #(
        .DB_COUNT(DB_COUNT)
      ) u_db (
        .clk    (clk),
        .rst    (rst),
        .sample (at_end_c && (col_sel == COL_W'(c))),
        .raw    (~kp_row[r]),
        .stable (key_state[K]),
        .rise   (rise_c[K])
      );
    end
  end

  // Lowest set pending bit wins.
  always_comb begin
    low_c = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) low_c = KEY_W'(i);
    end
  end

  assign pend_any_c = |pending;
  assign clr_c      = pend_any_c ? (NUM_KEYS'(1) << low_c) : '0;

  // Pending capture and issue; a disabled game drops everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      hit       <= 1'b0;
      hit_index <= '0;
    end else if (!enable) begin
      pending <= '0;
      hit     <= 1'b0;
    end else begin
      hit     <= pend_any_c;
      pending <= (pending & ~clr_c) | rise_c;
      if (pend_any_c) hit_index <= low_c;
    end
  end

endmodule

// File: doc/keypad_hit_scan.md
# keypad_hit_scan

Front-end input stage for the whack-a-mole game. It scans the 4x4 hole keypad, debounces every key, and turns each clean press into a single-cycle `hit` pulse with a 4-bit `hit_index`. These two outputs are exactly the `hit`/`hit_index` inputs that `control` consumes. Presses are only reported while the game is accepting hits, and simultaneous presses are serialized so that none is lost.

## Interface
- `SCAN_CYCLES`, default 100000: clock cycles each column is driven (1 ms at 100 MHz); must be ≥ 2.
- `DB_COUNT`, default 4: consecutive disagreeing samples a key needs before its debounced state flips; must be ≥ 1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  high while hits are accepted (game running); low discards presses.
- `kp_row`  in  4  keypad rows, active-low, externally pulled up; treated as already synchronized.
- `kp_col`  out  4  column drive, active-low; exactly one bit low at all times.
- `hit`  out  1  one-cycle pulse per accepted press.
- `hit_index`  out  4  key index `row*4 + col`; valid when `hit`=1, holds last value otherwise.
- `key_state`  out  16  debounced pressed state, bit i = key i.

## Operation
- **Scan**
  - `timer` counts 0..SCAN_CYCLES-1 and wraps. `col_sel` (0..3) advances on the wrap, 3→0.
  - `kp_col = ~(4'b0001 << col_sel)`, registered.
  - The sample point is the cycle where `timer == SCAN_CYCLES-1`, i.e. the end of dwell, which allows settling. At that point `raw[r] = ~kp_row[r]` is taken for key `r*4 + col_sel`, r = 0..3.
- **Debounce** (per key, evaluated only on its sample point)
  - If raw equals stable, the counter clears.
  - Otherwise the counter increments. On reaching DB_COUNT, stable takes raw and the counter clears.
  - Keys not in the sampled column are unchanged.
- **Press event**: a stable 0→1 transition, with `enable`=1 at the same edge, sets bit i of a 16-bit `pending` mask. Release (1→0) produces no event.
- **Issue**
  - Each cycle, if `enable`=1 and `pending`≠0, the lowest set bit k is selected. Next edge: `hit`←1, `hit_index`←k, pending[k]←0.
  - Otherwise `hit`←0.
  - At most one hit per cycle. Up to 4 presses from one column issue on consecutive cycles in ascending index order.
- **Simultaneous set/clear**: a new press on bit j in the same cycle that bit k issues sets j and clears k. A bit can never be set and issued in the same cycle.
- **enable low**
  - `pending` clears next edge and no new bits set. Scanning and debounce continue.
  - A key already held when `enable` rises produces no hit until it is released and pressed again.

## Timing
- Reset values: `timer`=0, `col_sel`=0, `kp_col`=4'b1110, all debounce counters 0, `key_state`=0, `pending`=0, `hit`=0, `hit_index`=0.
- Reset mid-scan or mid-issue discards all pending presses. A key held through reset reports once after its debounce completes.
- Full scan period: 4·SCAN_CYCLES cycles. Minimum acknowledged press: DB_COUNT consecutive samples of that key.
- Latency from the sample edge that flips stable to `hit` high: 1 cycle if lowest pending, +1 per lower-index pending bit.
- `hit` never stays high for two consecutive cycles for the same press.

## Structure
- Shared package `whack_pkg` holds:
  - `NUM_KEYS`=16, `KP_ROWS`=4, `KP_COLS`=4.
  - `key_idx_t` (logic [3:0]).
  - The key index function `row*4+col`.
- One sub-module, `key_debounce` (counter plus stable bit, with a sample strobe and raw input, outputs stable and rise), instantiated 16 times by generate.
- The scan timer, column select, pending mask and priority issue live in the top level.

## Test plan
All scenarios use SCAN_CYCLES=4, DB_COUNT=2, and `enable`=1 unless stated.
- **Reset**: `rst` high 3 cycles → `kp_col`=1110, `hit`=0, `key_state`=0. Then `kp_col` cycles 1110→1101→1011→0111 every 4 cycles.
- **Single press**: hold row 2 while col 1 is driven, for ≥ 2 scans → exactly one `hit` with `hit_index`=9 and `key_state[9]`=1. Release → no hit, `key_state[9]`→0 after 2 samples.
- **Bounce rejection**: key 6 is seen pressed on one sample and released on the next, repeated for 10 scans → no `hit` and `key_state[6]` stays 0.
- **Same-column burst**: rows 0, 1 and 3 pressed on col 1 together → hits on 3 consecutive cycles with index 1, 5, 13.
- **Enable gating**: press key 4 with `enable`=0, then raise `enable` while it is held → no hit. Release and press again → one hit, index 4. Dropping `enable` while a bit is pending → that press is never issued.
- **Reset mid-operation**: assert `rst` in the cycle between the 2nd-column sample and issue of a pending key 2 → no `hit`, `pending` cleared, scan restarts at col 0.
